// File: rtl/ula_n_if.sv
// Handshake/operand bus for ula_n: start/opcode/a/b toward the ALU, result and status back.
interface ula_n_if #(
  parameter int N = 8
) ();
  logic         start;
  logic [2:0]   opcode;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] s;
  logic         carry;
  logic         zero;
  logic         busy;
  logic         done;

  modport master (
    output start, opcode, a, b,
    input  s, carry, zero, busy, done
  );

  modport slave (
    input  start, opcode, a, b,
    output s, carry, zero, busy, done
  );
endinterface

// File: rtl/ula_n.sv
// N-bit multi-cycle ALU with start/busy/done handshake and registered result/flags.
// Define ULA_MUL_EN to build the N-cycle shift-add multiplier for opcode 101.
module ula_n #(
  parameter int N = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  ula_n_if.slave bus
);
  localparam int CW = $clog2(N);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_EQ  = 3'b110;
  localparam logic [2:0] OP_NEQ = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg;
  logic [2:0]      op_reg;
  logic [N-1:0]    a_reg;
  logic [N-1:0]    b_reg;
  logic [N-1:0]    sh_reg;
  logic [CW-1:0]   cnt_reg;
  logic [N-1:0]    s_reg;
  logic            carry_reg;
  logic            zero_reg;
  logic            busy_reg;
  logic            done_reg;

`ifdef ULA_MUL_EN
  localparam logic [CW-1:0] MUL_LAST = CW'(N - 1);
  logic [2*N-1:0]  acc_reg;
  logic [2*N-1:0]  mcand_reg;
  logic [N-1:0]    mplier_reg;
  logic [2*N-1:0]  acc_next;
`endif

  logic [CW-1:0]   shamt;
  logic [N-1:0]    res_next;
  logic            carry_next;
  logic            fin_next;

  assign shamt = b_reg[CW-1:0];

  // Result of the current RUN cycle; fin_next marks the cycle that commits it.
  always_comb begin
    res_next   = '0;
    carry_next = 1'b0;
    fin_next   = 1'b1;
`ifdef ULA_MUL_EN
    acc_next   = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
`endif
    unique case (op_reg)
      OP_ADD: {carry_next, res_next} = {1'b0, a_reg} + {1'b0, b_reg};
      OP_SUB: begin
        res_next   = a_reg - b_reg;
        carry_next = (a_reg < b_reg);
      end
      OP_XOR: res_next = a_reg ^ b_reg;
      OP_NOT: res_next = ~a_reg;
      OP_SHL: begin
        if (shamt == '0) begin
          res_next = a_reg;
        end else begin
          fin_next   = (cnt_reg == shamt - CW'(1));
          res_next   = {sh_reg[N-2:0], 1'b0};
          carry_next = sh_reg[N-1];
        end
      end
      OP_MUL: begin
`ifdef ULA_MUL_EN
        fin_next   = (cnt_reg == MUL_LAST);
        res_next   = acc_next[N-1:0];
        carry_next = |acc_next[2*N-1:N];
`else
        res_next   = '0;
`endif
      end
      OP_EQ:   res_next[0] = (a_reg == b_reg);
      OP_NEQ:  res_next[0] = (a_reg != b_reg);
      default: res_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      sh_reg     <= '0;
      cnt_reg    <= '0;
      s_reg      <= '0;
      carry_reg  <= 1'b0;
      zero_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
`ifdef ULA_MUL_EN
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
`endif
    end else begin
      unique case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            state_reg <= RUN;
            busy_reg  <= 1'b1;
            op_reg    <= bus.opcode;
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            sh_reg    <= bus.a;
            cnt_reg   <= '0;
`ifdef ULA_MUL_EN
            acc_reg    <= '0;
            mcand_reg  <= {{N{1'b0}}, bus.a};
            mplier_reg <= bus.b;
`endif
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          // Inputs are deliberately not looked at here; only latched operands matter.
          if (fin_next) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            s_reg     <= res_next;
            carry_reg <= carry_next;
            zero_reg  <= (res_next == '0);
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
            sh_reg  <= {sh_reg[N-2:0], 1'b0};
`ifdef ULA_MUL_EN
            acc_reg    <= acc_next;
            mcand_reg  <= {mcand_reg[2*N-2:0], 1'b0};
            mplier_reg <= {1'b0, mplier_reg[N-1:1]};
`endif
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s     = s_reg;
  assign bus.carry = carry_reg;
  assign bus.zero  = zero_reg;
  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;
endmodule

// File: tb/tb_ula_n.sv
// Self-checking bench for ula_n (N=8): transaction-level reference model checked every
// cycle, plus directed operations with hand-computed results and busy-cycle counts.
module tb_ula_n;
  localparam int N = 8;
`ifdef ULA_MUL_EN
  localparam int MUL_LAT = 8;
`else
  localparam int MUL_LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  ula_n_if #(.N(N)) bus ();
  ula_n #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what an operation must yield and how many RUN cycles it takes.
  function automatic void model_op(input logic [2:0] op, input logic [N-1:0] x,
                                   input logic [N-1:0] y, output logic [N-1:0] r,
                                   output logic c, output int lat);
    logic [2*N-1:0] p;
    int m;
    r = '0; c = 1'b0; lat = 1;
    case (op)
      3'd0: {c, r} = {1'b0, x} + {1'b0, y};
      3'd1: begin r = x - y; c = (x < y); end
      3'd2: r = x ^ y;
      3'd3: r = ~x;
      3'd4: begin
        m = int'(y) % N;
        if (m == 0) r = x;
        else begin r = x << m; c = x[N-m]; lat = m; end
      end
      3'd5: begin
`ifdef ULA_MUL_EN
        p = x * y;
        r = p[N-1:0];
        c = (p[2*N-1:N] != '0);
        lat = N;
`else
        p = '0;
        r = p[N-1:0];
`endif
      end
      3'd6: r = (x == y) ? N'(1) : N'(0);
      default: r = (x != y) ? N'(1) : N'(0);
    endcase
  endfunction

  // Expected outputs, advanced once per rising edge from the sampled inputs.
  logic [N-1:0] m_s = '0, p_s = '0;
  logic m_c = 1'b0, m_z = 1'b0, m_done = 1'b0, p_c = 1'b0, m_started = 1'b0;
  int   m_rem = 0;

  always @(posedge clk) begin
    int lat;
    m_started = 1'b1;
    if (!rst_n) begin
      m_rem = 0; m_done = 1'b0; m_s = '0; m_c = 1'b0; m_z = 1'b0;
    end else if (m_rem != 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_s = p_s; m_c = p_c; m_z = (p_s == '0); m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (bus.start) begin
        model_op(bus.opcode, bus.a, bus.b, p_s, p_c, lat);
        m_rem = lat;
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("cyc_s",     bus.s,     m_s);
      check("cyc_carry", bus.carry, m_c);
      check("cyc_zero",  bus.zero,  m_z);
      check("cyc_busy",  bus.busy,  (m_rem != 0));
      check("cyc_done",  bus.done,  m_done);
    end
  end

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [N-1:0] x,
                        input logic [N-1:0] y, input logic [N-1:0] es, input logic ec,
                        input logic ez, input int ebusy, input bit hold);
    int bc = 0;
    int guard = 0;
    bus.start = 1'b1; bus.opcode = op; bus.a = x; bus.b = y;
    @(negedge clk);
    while (bus.done !== 1'b1 && guard < 200) begin
      if (bus.busy === 1'b1) bc++;
      if (hold) begin
        bus.start = 1'b1;
        bus.opcode = bus.opcode + 3'd1;
        bus.a = bus.a ^ 8'h5A;
        bus.b = bus.b + 8'd3;
      end else begin
        bus.start = 1'b0;
      end
      guard++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, "_done"},  bus.done,  1'b1);
    check({tag, "_s"},     bus.s,     es);
    check({tag, "_carry"}, bus.carry, ec);
    check({tag, "_zero"},  bus.zero,  ez);
    check({tag, "_busy"},  bc,        ebusy);
    $display("[TB] %s op=%0d a=%02h b=%02h -> s=%02h carry=%0b zero=%0b busy_cycles=%0d",
             tag, op, x, y, bus.s, bus.carry, bus.zero, bc);
  endtask

  initial begin
    logic [N-1:0] ts;
    logic tc;
    int tl;
    bus.start = 1'b0; bus.opcode = '0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    check("rst_s", bus.s, 8'h00);
    check("rst_flags", {bus.carry, bus.zero, bus.busy, bus.done}, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);

    // Pin the reference model itself against hand-computed values.
    model_op(3'd0, 8'd200, 8'd100, ts, tc, tl);
    check("model_add", {ts, tc}, {8'd44, 1'b1});
    model_op(3'd4, 8'h81, 8'd3, ts, tc, tl);
    check("model_shl", {ts, tc, 8'(tl)}, {8'h08, 1'b0, 8'd3});

    run_op("add",    3'd0, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0, 1, 1'b0);
    @(negedge clk);
    run_op("sub_bw", 3'd1, 8'd5,   8'd7,   8'd254, 1'b1, 1'b0, 1, 1'b0);
    @(negedge clk);
    run_op("sub_eq", 3'd1, 8'd9,   8'd9,   8'd0,   1'b0, 1'b1, 1, 1'b0);
    @(negedge clk);
`ifdef ULA_MUL_EN
    run_op("mul1",   3'd5, 8'd15,  8'd17,  8'd255, 1'b0, 1'b0, MUL_LAT, 1'b0);
    @(negedge clk);
    run_op("mul2",   3'd5, 8'd16,  8'd16,  8'd0,   1'b1, 1'b1, MUL_LAT, 1'b0);
`else
    run_op("mul1",   3'd5, 8'd15,  8'd17,  8'd0,   1'b0, 1'b1, MUL_LAT, 1'b0);
    @(negedge clk);
    run_op("mul2",   3'd5, 8'd16,  8'd16,  8'd0,   1'b0, 1'b1, MUL_LAT, 1'b0);
`endif
    @(negedge clk);
    run_op("shl3",   3'd4, 8'h81,  8'd3,   8'h08,  1'b0, 1'b0, 3, 1'b0);
    @(negedge clk);
    run_op("shl11",  3'd4, 8'h81,  8'd11,  8'h08,  1'b0, 1'b0, 3, 1'b0);
    @(negedge clk);
    run_op("shl8",   3'd4, 8'h81,  8'd8,   8'h81,  1'b0, 1'b0, 1, 1'b0);
    @(negedge clk);
    run_op("shl1c",  3'd4, 8'hC0,  8'd1,   8'h80,  1'b1, 1'b0, 1, 1'b0);
    @(negedge clk);
    run_op("xor",    3'd2, 8'hF0,  8'h3C,  8'hCC,  1'b0, 1'b0, 1, 1'b0);
    @(negedge clk);
    run_op("not",    3'd3, 8'hFF,  8'h12,  8'h00,  1'b0, 1'b1, 1, 1'b0);
    @(negedge clk);
    run_op("neq",    3'd7, 8'h01,  8'h02,  8'h01,  1'b0, 1'b0, 1, 1'b0);
    @(negedge clk);

    // Inputs toggling with start held high during a multiply must be ignored.
`ifdef ULA_MUL_EN
    run_op("mul_hold", 3'd5, 8'd15, 8'd17, 8'd255, 1'b0, 1'b0, MUL_LAT, 1'b1);
`else
    run_op("mul_hold", 3'd5, 8'd15, 8'd17, 8'd0,   1'b0, 1'b1, MUL_LAT, 1'b1);
`endif
    @(negedge clk);

    // Back-to-back: each new start lands during DONE.
    run_op("b2b_add", 3'd0, 8'd1,  8'd2,  8'd3,  1'b0, 1'b0, 1, 1'b0);
    run_op("b2b_sub", 3'd1, 8'd10, 8'd4,  8'd6,  1'b0, 1'b0, 1, 1'b0);
    run_op("b2b_eq",  3'd6, 8'd7,  8'd8,  8'd0,  1'b0, 1'b1, 1, 1'b0);
    @(negedge clk);

    // Reset in the 4th RUN cycle of a long operation.
    run_op("pre_rst", 3'd0, 8'd200, 8'd100, 8'd44, 1'b1, 1'b0, 1, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
`ifdef ULA_MUL_EN
    bus.opcode = 3'd5; bus.a = 8'd15; bus.b = 8'd17;
`else
    bus.opcode = 3'd4; bus.a = 8'hFF; bus.b = 8'd7;
`endif
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_s", bus.s, 8'h00);
    check("rst_mid_flags", {bus.carry, bus.zero, bus.busy, bus.done}, 4'b0000);
    $display("[TB] reset mid-run -> s=%02h carry=%0b zero=%0b busy=%0b done=%0b",
             bus.s, bus.carry, bus.zero, bus.busy, bus.done);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("eq_post", 3'd6, 8'h3C, 8'h3C, 8'h01, 1'b0, 1'b0, 1, 1'b0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
